// File: rtl/radio_wired_combiner.sv
// Radio/Wired differential symbol combiner: sync-word hunt, word deserializer and output FIFO.
// Define PARITY_CHECK_EN to expect one even-parity bit after every payload word.
module radio_wired_combiner #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       SYNC_W     = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       ERR_LIMIT  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic              radio,
  input  logic              wired,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              overflow,
  output logic [7:0]        err_count
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned BitCntW = $clog2(DATA_W);
  localparam int unsigned FaultW  = $clog2(ERR_LIMIT + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {StHunt, StData, StParity} state_e;
`else
  typedef enum logic [1:0] {StHunt, StData} state_e;
`endif

  state_e               state_q, state_d;
  logic [SYNC_W-1:0]    sync_q, sync_d;
  logic [DATA_W-1:0]    word_q, word_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FaultW-1:0]    fault_cnt_q, fault_cnt_d;
  logic [7:0]           err_q, err_d;
  logic [1:0]           radio_sync_q, wired_sync_q;
  logic                 sym_val, sym_bit, sym_fault;
  logic                 push_req, par_err;
  logic [DATA_W-1:0]    push_word;

  logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 overflow_q;
  logic                 full, push, pop;

  // Pins are asynchronous to clk: two-flop synchronizers on each leg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      radio_sync_q <= '0;
      wired_sync_q <= '0;
    end else begin
      radio_sync_q <= {radio_sync_q[0], radio};
      wired_sync_q <= {wired_sync_q[0], wired};
    end
  end

  assign sym_val   = sample_en & (radio_sync_q[1] ^ wired_sync_q[1]);
  assign sym_bit   = radio_sync_q[1];
  assign sym_fault = sample_en & radio_sync_q[1] & wired_sync_q[1];

  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    word_d      = word_q;
    bit_cnt_d   = bit_cnt_q;
    fault_cnt_d = fault_cnt_q;
    push_req    = 1'b0;
    push_word   = word_q;
    par_err     = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (sym_val) begin
          sync_d = {sync_q[SYNC_W-2:0], sym_bit};
          if (sync_d == SYNC_WORD) begin
            state_d     = StData;
            bit_cnt_d   = '0;
            fault_cnt_d = '0;
          end
        end else if (sym_fault) begin
          sync_d = '0;
        end
      end
      StData: begin
        if (sym_val) begin
          fault_cnt_d = '0;
          word_d      = {word_q[DATA_W-2:0], sym_bit};
          if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d   = StParity;
`else
            push_req  = 1'b1;
            push_word = word_d;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef PARITY_CHECK_EN
      StParity: begin
        if (sym_val) begin
          fault_cnt_d = '0;
          state_d     = StData;
          if (sym_bit == ^word_q) begin
            push_req = 1'b1;
          end else begin
            par_err = 1'b1;
          end
        end
      end
`endif
      default: state_d = StHunt;
    endcase

    // Consecutive faults while locked; the limit discards the partial word.
    if (sym_fault && state_q != StHunt) begin
      if (fault_cnt_q == FaultW'(ERR_LIMIT - 1)) begin
        state_d     = StHunt;
        sync_d      = '0;
        word_d      = '0;
        bit_cnt_d   = '0;
        fault_cnt_d = '0;
      end else begin
        fault_cnt_d = fault_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if ((sym_fault || par_err) && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHunt;
      sync_q      <= '0;
      word_q      <= '0;
      bit_cnt_q   <= '0;
      fault_cnt_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      word_q      <= word_d;
      bit_cnt_q   <= bit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      err_q       <= err_d;
    end
  end

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push  = push_req & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_req & ~push;
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign locked    = (state_q != StHunt);
  assign overflow  = overflow_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_radio_wired_combiner.sv
// Self-checking bench for radio_wired_combiner: symbol-level reference model plus scoreboard.
// Honours PARITY_CHECK_EN the same way as the design.
module tb_radio_wired_combiner;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ERR_LIMIT  = 3;
  localparam logic [7:0]  SYNC_WORD  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       radio = 1'b0;
  logic       wired = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       locked;
  logic       overflow;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  radio_wired_combiner dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .radio     (radio),
    .wired     (wired),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .overflow  (overflow),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen = 0;
  // Sample_En has no synchronizer, so it is driven two cycles after its symbol's pins.
  logic en_d1 = 1'b0;
  logic en_d2 = 1'b0;

  bit         m_locked, m_par_wait, m_hold;
  int         m_sync, m_word, m_nbits, m_faults, m_err, m_occ, m_ovf;
  logic [7:0] exp_q[$];

  task automatic model_reset();
    m_locked = 0; m_par_wait = 0; m_hold = 0;
    m_sync = 0; m_word = 0; m_nbits = 0; m_faults = 0; m_err = 0; m_occ = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [7:0] v);
    if (!m_hold) begin
      exp_q.push_back(v);
    end else if (m_occ < FIFO_DEPTH) begin
      exp_q.push_back(v);
      m_occ++;
    end else begin
      m_ovf++;
    end
  endtask

  task automatic model_sym(input logic r, input logic w);
    logic b;
    if (r == w) begin
      if (r) begin
        if (m_err < 255) m_err++;
        if (!m_locked) begin
          m_sync = 0;
        end else begin
          m_faults++;
          if (m_faults == ERR_LIMIT) begin
            m_locked = 0; m_sync = 0; m_nbits = 0; m_faults = 0; m_par_wait = 0;
          end
        end
      end
      return;
    end
    b = r;
    if (!m_locked) begin
      m_sync = ((m_sync << 1) | int'(b)) & 'hFF;
      if (m_sync == int'(SYNC_WORD)) begin
        m_locked = 1; m_nbits = 0; m_faults = 0;
      end
    end else begin
      m_faults = 0;
      if (m_par_wait) begin
        m_par_wait = 0;
        if (int'(b) == ($countones(m_word) % 2)) model_push(m_word[7:0]);
        else if (m_err < 255) m_err++;
      end else begin
        m_word = ((m_word << 1) | int'(b)) & 'hFF;
        m_nbits++;
        if (m_nbits == DATA_W) begin
          m_nbits = 0;
`ifdef PARITY_CHECK_EN
          m_par_wait = 1;
`else
          model_push(m_word[7:0]);
`endif
        end
      end
    end
  endtask

  // One clock of stimulus; also runs the output scoreboard and overflow tally.
  task automatic cycle(input logic r, input logic w, input logic en, input logic rdy);
    logic [7:0] exp;
    radio = r;
    wired = w;
    sample_en = en_d2;
    en_d2 = en_d1;
    en_d1 = en;
    out_ready = rdy;
    if (en) model_sym(r, w);
    #1;
    if (overflow === 1'b1) ovf_seen++;
    if (out_valid === 1'b1 && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got word %h, expected no word", out_data);
      end else begin
        exp = exp_q.pop_front();
        if (out_data !== exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h, expected %h", out_data, exp);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    cycle(b, ~b, 1'b1, rdy);
  endtask

  task automatic send_fault(input logic rdy);
    cycle(1'b1, 1'b1, 1'b1, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, rdy);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rdy);
    for (int i = 7; i >= 0; i--) send_bit(v[i], rdy);
  endtask

  task automatic send_word(input logic [7:0] v, input logic rdy);
    send_byte(v, rdy);
`ifdef PARITY_CHECK_EN
    send_bit(^v, rdy);
`endif
  endtask

  task automatic do_reset();
    radio = 0; wired = 0; sample_en = 0; en_d1 = 0; en_d2 = 0; out_ready = 0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    ovf_seen = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] part;
    part = 8'hF0;
    n_checks++;
    if ({out_valid, out_data, locked, overflow, err_count} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got outputs %h, expected 0",
               {out_valid, out_data, locked, overflow, err_count});
    end
    do_reset();
    send_fault(1'b0);
    send_byte(SYNC_WORD, 1'b0);
    send_word(8'h11, 1'b0);
    idle(3, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(part[i], 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || locked !== 1'b1 || err_count !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL reset_pre: got valid=%b locked=%b err=%0d, expected 1 1 %0d",
               out_valid, locked, err_count, m_err);
    end
    radio = 0; wired = 0; sample_en = 0; en_d1 = 0; en_d2 = 0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, locked, overflow, err_count} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_async: got outputs %h, expected 0",
               {out_valid, out_data, locked, overflow, err_count});
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 3; i >= 0; i--) send_bit(part[i], 1'b1);
    send_word(8'h3C, 1'b1);
    idle(6, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_after: got valid=%b locked=%b, expected 0 0", out_valid, locked);
    end
  endtask

  task automatic test_sync_latency();
    do_reset();
    idle(2, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(SYNC_WORD[i], 1'b1);
    send_bit(SYNC_WORD[0], 1'b1);
    idle(1, 1'b1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: got locked=%b, expected 0", locked);
    end
    idle(1, 1'b1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_latency: got locked=%b, expected 1", locked);
    end
    send_word(8'h3C, 1'b1);
    idle(1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_early: got valid=%b, expected 0", out_valid);
    end
    idle(1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL valid_latency: got valid=%b data=%h, expected 1 3c", out_valid, out_data);
    end
    idle(3, 1'b1);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_drain: got pending=%0d valid=%b, expected 0 0", exp_q.size(),
               out_valid);
    end
  endtask

  task automatic test_faults();
    logic [7:0] v;
    v = 8'hBD;
    do_reset();
    send_byte(SYNC_WORD, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(v[i], 1'b1);
    send_fault(1'b1);
    send_fault(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(v[i], 1'b1);
`ifdef PARITY_CHECK_EN
    send_bit(^v, 1'b1);
`endif
    idle(5, 1'b1);
    n_checks++;
    if (locked !== 1'b1 || err_count !== 8'(m_err) || m_err != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL two_faults: got locked=%b err=%0d pending=%0d, expected 1 2 0", locked,
               err_count, exp_q.size());
    end
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_fault(1'b1);
    idle(5, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || err_count !== 8'(m_err) || m_err != 5) begin
      n_fail++;
      $display("FAIL three_faults: got locked=%b err=%0d, expected 0 5", locked, err_count);
    end
    send_byte(8'h0F, 1'b1);
    idle(5, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL partial_dropped: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    m_hold = 1;
    send_byte(SYNC_WORD, 1'b0);
    for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
    idle(3, 1'b0);
    n_checks++;
    if (ovf_seen != 0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_early: got pulses=%0d valid=%b, expected 0 1", ovf_seen, out_valid);
    end
    send_word(8'h05, 1'b0);
    idle(3, 1'b0);
    n_checks++;
    if (ovf_seen != m_ovf || m_ovf != 1) begin
      n_fail++;
      $display("FAIL ovf_pulse: got pulses=%0d, expected %0d", ovf_seen, m_ovf);
    end
    m_hold = 0;
    idle(8, 1'b1);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain: got pending=%0d valid=%b, expected 0 0", exp_q.size(),
               out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(SYNC_WORD, 1'b0);
    for (int k = 1; k <= 4; k++) send_word(8'h10 + 8'(k), 1'b0);
    idle(3, 1'b0);
    send_word(8'h15, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);  // pop lands on the same edge as the push of 8'h15
    idle(3, 1'b0);
    n_checks++;
    if (ovf_seen != 0 || exp_q.size() != 4) begin
      n_fail++;
      $display("FAIL coincident_push_pop: got pulses=%0d pending=%0d, expected 0 4", ovf_seen,
               exp_q.size());
    end
    idle(8, 1'b1);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_drain: got pending=%0d valid=%b, expected 0 0", exp_q.size(),
               out_valid);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    do_reset();
    send_byte(SYNC_WORD, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_bit(1'b1, 1'b1);
    idle(4, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 8'(m_err) || m_err != 1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_bad: got valid=%b err=%0d locked=%b, expected 0 1 1", out_valid,
               err_count, locked);
    end
    send_byte(8'h3C, 1'b1);
    send_bit(1'b0, 1'b1);
    idle(5, 1'b1);
    n_checks++;
    if (exp_q.size() != 0 || err_count !== 8'(m_err) || m_err != 1) begin
      n_fail++;
      $display("FAIL parity_good: got pending=%0d err=%0d, expected 0 1", exp_q.size(),
               err_count);
    end
  endtask
`endif

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) send_fault(1'b1);
    idle(4, 1'b1);
    n_checks++;
    if (err_count !== 8'(m_err) || m_err != 255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d, expected %0d", err_count, m_err);
    end
  endtask

  task automatic test_random();
    int   stall;
    int   pick;
    logic rdy;
    logic r, w, en;
    stall = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = 1'b1;
        if ($urandom_range(0, 7) == 0) stall = $urandom_range(1, 3);
      end
      if (!m_locked && $urandom_range(0, 19) == 0) begin
        send_byte(SYNC_WORD, rdy);
      end else begin
        pick = $urandom_range(0, 19);
        en = ($urandom_range(0, 9) != 0);
        if (pick < 16) begin
          r = 1'($urandom_range(0, 1));
          w = ~r;
        end else if (pick < 18) begin
          r = 1'b0; w = 1'b0;
        end else begin
          r = 1'b1; w = 1'b1;
        end
        cycle(r, w, en, rdy);
      end
    end
    idle(10, 1'b1);
    n_checks++;
    if (exp_q.size() != 0 || err_count !== 8'(m_err) || locked !== m_locked || ovf_seen != 0)
    begin
      n_fail++;
      $display("FAIL random_end: got pending=%0d err=%0d locked=%b ovf=%0d, expected 0 %0d %b 0",
               exp_q.size(), err_count, locked, ovf_seen, m_err, m_locked);
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_sync_latency();
    test_faults();
    test_overflow();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
